// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS-subset control FSM.
// Opcodes, funct codes, state encodings, ALU and PC-source codes.
package mc_ctrl_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BLTZ  = 6'b000001;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

  localparam logic [OP_W-1:0] FN_SLL = 6'b000000;
  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef enum logic [2:0] {
    ST_IF   = 3'b000,
    ST_ID   = 3'b001,
    ST_EXE  = 3'b010,
    ST_MEM  = 3'b011,
    ST_WB   = 3'b100,
    ST_HALT = 3'b101
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SLL = 3'b010,
    ALU_OR  = 3'b011,
    ALU_AND = 3'b100,
    ALU_SLT = 3'b101
  } alu_ctr_e;

  typedef struct packed {
    logic     legal;
    logic     src_a;
    logic     src_b;
    logic     ext_op;
    alu_ctr_e ctr;
  } alu_dec_t;

  function automatic logic is_branch_op(logic [OP_W-1:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ);
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: IR fields and ALU flags in, strobes/muxes out.
// MC_CTRL_PERF_EN adds the cyc_cnt/ret_cnt performance counters.
interface mc_controller_if
`ifdef MC_CTRL_PERF_EN
  #(parameter int unsigned CNT_W = 32)
`endif
  ;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       sign;
  logic       mem_ready;
  logic       IRwrt;
  logic       PCwrt;
  logic [1:0] PCsrc;
  logic       regWrt;
  logic       ALUsrcA;
  logic       ALUsrcB;
  logic [2:0] ALUctr;
  logic       extOp;
  logic       memRd;
  logic       memWrt;
  logic       halted;
  logic       mem_err;
  logic [2:0] state;
`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] ret_cnt;
`endif

  modport master (
    input  op, funct, zero, sign, mem_ready,
    output IRwrt, PCwrt, PCsrc, regWrt, ALUsrcA, ALUsrcB, ALUctr, extOp,
           memRd, memWrt, halted, mem_err, state
`ifdef MC_CTRL_PERF_EN
           , cyc_cnt, ret_cnt
`endif
  );

  modport slave (
    output op, funct, zero, sign, mem_ready,
    input  IRwrt, PCwrt, PCsrc, regWrt, ALUsrcA, ALUsrcB, ALUctr, extOp,
           memRd, memWrt, halted, mem_err, state
`ifdef MC_CTRL_PERF_EN
           , cyc_cnt, ret_cnt
`endif
  );

endinterface

// File: rtl/mc_alu_decode.sv
// Combinational op/funct decode into ALU operand selects, ALU op, extension
// mode and a legal flag for recognised instructions.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output alu_dec_t   dec_c_o
);

  always_comb begin
    dec_c_o        = '0;
    dec_c_o.legal  = 1'b1;
    dec_c_o.src_a  = 1'b1;
    dec_c_o.ctr    = ALU_ADD;
    case (op_i)
      OP_RTYPE: begin
        dec_c_o.src_b = 1'b1;
        case (funct_i)
          FN_ADD:  dec_c_o.ctr = ALU_ADD;
          FN_SUB:  dec_c_o.ctr = ALU_SUB;
          FN_AND:  dec_c_o.ctr = ALU_AND;
          FN_OR:   dec_c_o.ctr = ALU_OR;
          FN_SLL: begin
            dec_c_o.src_a = 1'b0;
            dec_c_o.ctr   = ALU_SLL;
          end
          default: dec_c_o.legal = 1'b0;
        endcase
      end
      OP_ADDIU: dec_c_o.ext_op = 1'b1;
      OP_SLTI: begin
        dec_c_o.ext_op = 1'b1;
        dec_c_o.ctr    = ALU_SLT;
      end
      OP_ANDI: dec_c_o.ctr = ALU_AND;
      OP_ORI:  dec_c_o.ctr = ALU_OR;
      OP_LW, OP_SW: dec_c_o.ext_op = 1'b1;
      // bltz compares rs against rt=$0, so it shares the beq/bne setup
      OP_BEQ, OP_BNE, OP_BLTZ: begin
        dec_c_o.src_b = 1'b1;
        dec_c_o.ctr   = ALU_SUB;
      end
      OP_J, OP_HALT: dec_c_o.src_a = 1'b0;
      default: dec_c_o.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle IF/ID/EXE/MEM/WB control FSM with memory ready/timeout handling.
// Define MC_CTRL_PERF_EN to add the cycle and retire performance counters.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mc_controller_if.master    bus
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  if (CNT_W == 0) begin : g_cnt_w_chk
    $error("CNT_W must be non-zero");
  end

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_err_q, mem_err_d;

  alu_dec_t   dec;
  logic       is_lw, is_sw, is_br, br_taken, timeout_hit;
  logic       ir_wrt, pc_wrt, reg_wrt, mem_rd, mem_wrt;
  logic       alu_src_a, alu_src_b, ext_op;
  logic [1:0] pc_src;
  logic [2:0] alu_ctr;

  mc_alu_decode u_alu_decode (
    .op_i    (bus.op),
    .funct_i (bus.funct),
    .dec_c_o (dec)
  );

  assign is_lw       = (bus.op == OP_LW);
  assign is_sw       = (bus.op == OP_SW);
  assign is_br       = is_branch_op(bus.op);
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);

  always_comb begin
    case (bus.op)
      OP_BEQ:  br_taken = bus.zero;
      OP_BNE:  br_taken = ~bus.zero;
      OP_BLTZ: br_taken = bus.sign;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IF;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    ir_wrt    = 1'b0;
    pc_wrt    = 1'b0;
    pc_src    = PCSRC_SEQ;
    reg_wrt   = 1'b0;
    mem_rd    = 1'b0;
    mem_wrt   = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_ctr   = ALU_ADD;
    ext_op    = 1'b0;

    // ALU setup is established in EXE and held until the instruction retires
    if (state_q inside {ST_EXE, ST_MEM, ST_WB}) begin
      alu_src_a = dec.src_a;
      alu_src_b = dec.src_b;
      alu_ctr   = dec.ctr;
      ext_op    = dec.ext_op;
    end

    case (state_q)
      ST_IF: begin
        ir_wrt  = 1'b1;
        state_d = ST_ID;
      end
      ST_ID: begin
        if (bus.op == OP_J) begin
          pc_wrt  = 1'b1;
          pc_src  = PCSRC_JMP;
          state_d = ST_IF;
        end else if (bus.op == OP_HALT) begin
          state_d = ST_HALT;
        end else if (!dec.legal) begin
          pc_wrt  = 1'b1;
          state_d = ST_IF;
        end else begin
          state_d = ST_EXE;
        end
      end
      ST_EXE: begin
        if (is_br) begin
          pc_wrt  = 1'b1;
          pc_src  = br_taken ? PCSRC_BR : PCSRC_SEQ;
          state_d = ST_IF;
        end else if (is_lw || is_sw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_rd  = is_lw;
        mem_wrt = is_sw;
        // a completion arriving on the last allowed cycle beats the timeout
        if (bus.mem_ready) begin
          wait_d = '0;
          if (is_sw) begin
            pc_wrt  = 1'b1;
            state_d = ST_IF;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout_hit) begin
          wait_d    = '0;
          mem_err_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WB: begin
        reg_wrt = 1'b1;
        pc_wrt  = 1'b1;
        state_d = ST_IF;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IF;
    endcase
  end

  // Strobes are forced low while reset is held so nothing fires mid-abort
  assign bus.IRwrt   = ir_wrt  & rst_n;
  assign bus.PCwrt   = pc_wrt  & rst_n;
  assign bus.regWrt  = reg_wrt & rst_n;
  assign bus.memRd   = mem_rd  & rst_n;
  assign bus.memWrt  = mem_wrt & rst_n;
  assign bus.PCsrc   = pc_src;
  assign bus.ALUsrcA = alu_src_a;
  assign bus.ALUsrcB = alu_src_b;
  assign bus.ALUctr  = alu_ctr;
  assign bus.extOp   = ext_op;
  assign bus.halted  = (state_q == ST_HALT);
  assign bus.mem_err = mem_err_q;
  assign bus.state   = state_q;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_cnt_q, ret_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      if (state_q != ST_HALT) cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
      if (pc_wrt)             ret_cnt_q <= ret_cnt_q + CNT_W'(1);
    end
  end

  assign bus.cyc_cnt = cyc_cnt_q;
  assign bus.ret_cnt = ret_cnt_q;
`endif

endmodule
